// File: rtl/fpnew_order_arb.sv
// In-order result arbiter: records the dispatch order of operations to slices and
// releases slice results strictly in that order. Optional macro: FPNEW_ORDER_STALL_CNT_EN.
module fpnew_order_arb #(
    parameter int unsigned NumSlices = 4,
    parameter int unsigned Depth     = 8,
    parameter int unsigned DataWidth = 38,
    localparam int unsigned IdxWidth = (NumSlices > 1) ? $clog2(NumSlices) : 1,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           issue_valid_i,
    input  logic [IdxWidth-1:0]            issue_slice_i,
    output logic                           issue_ready_o,
    input  logic [NumSlices-1:0]           slice_valid_i,
    input  logic [NumSlices*DataWidth-1:0] slice_data_i,
    output logic [NumSlices-1:0]           slice_ready_o,
    output logic                           out_valid_o,
    output logic [DataWidth-1:0]           out_data_o,
    input  logic                           out_ready_i,
    output logic [CntWidth-1:0]            occupancy_o,
    output logic                           err_o
`ifdef FPNEW_ORDER_STALL_CNT_EN
    ,
    output logic [31:0]                    stall_cnt_o
`endif
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam logic [IdxWidth:0] NumSlicesW = (IdxWidth + 1)'(NumSlices);

    logic [IdxWidth-1:0] mem_q [Depth];
    logic [IdxWidth-1:0] mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                full, empty, head_valid, push, pop, in_range;
    logic [IdxWidth-1:0] head;

    always_comb begin
        full          = (cnt_q == CntWidth'(Depth));
        empty         = (cnt_q == '0);
        head          = mem_q[rd_ptr_q];
        in_range      = ({1'b0, issue_slice_i} < NumSlicesW);
        issue_ready_o = !full && !flush_i;

        // Decode the head index by comparison so no out-of-range bit select is ever formed.
        head_valid    = 1'b0;
        out_data_o    = '0;
        slice_ready_o = '0;
        for (int unsigned i = 0; i < NumSlices; i++) begin
            if (head == IdxWidth'(i)) begin
                head_valid       = slice_valid_i[i];
                out_data_o       = slice_data_i[i*DataWidth +: DataWidth];
                slice_ready_o[i] = out_ready_i && !empty && !flush_i;
            end
        end

        out_valid_o = !empty && !flush_i && head_valid;
        push        = issue_valid_i && issue_ready_o && in_range;
        pop         = out_valid_o && out_ready_i;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q || (issue_valid_i && issue_ready_o && !in_range);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = issue_slice_i;
                wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntWidth'(1);
                2'b01:   cnt_d = cnt_q - CntWidth'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign occupancy_o = cnt_q;
    assign err_o       = err_q;

`ifdef FPNEW_ORDER_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!empty && !head_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/fpnew_order_arb.md
FPNEW_ORDER_ARB -- requirements
Module: fpnew_order_arb

Interface
REQ-001 Parameter NumSlices, default 4: number of result-producing slices (1..16).
REQ-002 Parameter Depth, default 8: order-queue entries; power of two, >= 2.
REQ-003 Parameter DataWidth, default 38: width of each slice result word (result + status + ext bit).
REQ-004 Derived IdxWidth = max(1, clog2(NumSlices)); CntWidth = clog2(Depth+1).
REQ-005 clk_i  in  1  Sole clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1  Asynchronous, active-low reset.
REQ-007 flush_i  in  1  Synchronous discard of all queued order entries.
REQ-008 issue_valid_i  in  1  An operation is being dispatched to a slice.
REQ-009 issue_slice_i  in  IdxWidth  Index of the slice that receives the operation.
REQ-010 issue_ready_o  out  1  Order queue can record the dispatch.
REQ-011 slice_valid_i  in  NumSlices  Per-slice result valid.
REQ-012 slice_data_i  in  NumSlices x DataWidth  Per-slice result words.
REQ-013 slice_ready_o  out  NumSlices  Per-slice result accept.
REQ-014 out_valid_o  out  1  In-order result valid.
REQ-015 out_data_o  out  DataWidth  In-order result word.
REQ-016 out_ready_i  in  1  Downstream accept.
REQ-017 occupancy_o  out  CntWidth  Entries currently queued.
REQ-018 err_o  out  1  Sticky flag: an out-of-range issue_slice_i was presented.

Function
REQ-019 A push SHALL occur when issue_valid_i && issue_ready_o && issue_slice_i < NumSlices; the slice index is written at the write pointer.
REQ-020 issue_ready_o SHALL equal !full && !flush_i; it SHALL NOT depend on same-cycle pop.
REQ-021 Head index SHALL be the entry at the read pointer; out_valid_o = !empty && !flush_i && slice_valid_i[head].
REQ-022 out_data_o SHALL equal slice_data_i[head] combinationally (zero-cycle latency); it is don't-care when out_valid_o is 0.
REQ-023 slice_ready_o[i] SHALL be 1 only for i == head, with value out_ready_i && !empty && !flush_i; all other bits 0.
REQ-024 A pop SHALL occur when out_valid_o && out_ready_i; the read pointer advances by one.
REQ-025 Results from non-head slices SHALL stall (ready 0) regardless of validity, enforcing dispatch order.
REQ-026 Pointers SHALL wrap modulo Depth; full when count == Depth, empty when count == 0.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-028 An out-of-range issue_slice_i with issue_valid_i && issue_ready_o SHALL not push and SHALL set err_o, which stays 1 until reset.
REQ-029 flush_i SHALL zero both pointers and count at the next edge; a push or pop in the flush cycle SHALL be suppressed; err_o is unaffected.
REQ-030 occupancy_o SHALL equal the registered count.

Reset
REQ-031 On rst_ni low, pointers, count, err_o and any statistics counter SHALL clear to 0 asynchronously.
REQ-032 Out of reset: issue_ready_o = 1, out_valid_o = 0, slice_ready_o = 0, occupancy_o = 0.
REQ-033 Reset asserted mid-operation SHALL drop all queued entries without any further pop.

Configuration
REQ-034 Macro FPNEW_ORDER_STALL_CNT_EN: when defined, port stall_cnt_o (out, 32) SHALL count cycles with !empty && !slice_valid_i[head], saturating at 0xFFFFFFFF, cleared by reset only; when undefined the port and counter SHALL not exist and all other behaviour is identical.

Verification
REQ-035 Reset, issue slices 2,0,1; slice 1 valid cycle 1, slice 0 cycle 2, slice 2 cycle 3 -> outputs in order 2,0,1, slice 2 data first on cycle 3.
REQ-036 Depth=8: 8 issues without pop -> issue_ready_o = 0, occupancy_o = 8; one pop -> issue_ready_o = 1 next cycle.
REQ-037 Count 3, push and pop same cycle -> occupancy_o stays 3; 20 cycles of continuous traffic -> pointer wrap, order preserved.
REQ-038 Count 5, flush_i pulse with issue_valid_i = 1 -> next cycle occupancy_o = 0, out_valid_o = 0, no push recorded.
REQ-039 NumSlices=3, issue_slice_i = 3 -> occupancy unchanged, err_o = 1 until rst_ni low.
REQ-040 With FPNEW_ORDER_STALL_CNT_EN, head slice invalid for 7 cycles -> stall_cnt_o = 7; without macro, REQ-035 results identical.
